// File: rtl/pcie_datalink_pkg.sv
// Shared DLLP definitions for the data link layer: field layout, FC type codes, CRC constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pcie_datalink_pkg;

    // One FC DLLP dword as it sits on the 32-bit stream (byte0 in [7:0], byte3 in [31:24]).
    typedef struct packed {
        logic [7:0] data_lo;   // byte3: DataFC[7:0]
        logic [1:0] hdr_lo;    // byte2[7:6]: HdrFC[1:0]
        logic [1:0] rsvd_b2;
        logic [3:0] data_hi;   // byte2[3:0]: DataFC[11:8]
        logic [1:0] rsvd_b1;
        logic [5:0] hdr_hi;    // byte1[5:0]: HdrFC[7:2]
        logic [3:0] typ;       // byte0[7:4]
        logic       rsvd_b0;
        logic [2:0] vc;        // byte0[2:0]
    } dllp_fc_t;

    localparam logic [3:0] DLLP_INITFC1_P   = 4'h4;
    localparam logic [3:0] DLLP_INITFC1_NP  = 4'h5;
    localparam logic [3:0] DLLP_INITFC1_CPL = 4'h6;
    localparam logic [3:0] DLLP_INITFC2_P   = 4'hC;
    localparam logic [3:0] DLLP_INITFC2_NP  = 4'hD;
    localparam logic [3:0] DLLP_INITFC2_CPL = 4'hE;
    localparam logic [3:0] DLLP_UPDATEFC_P   = 4'h8;
    localparam logic [3:0] DLLP_UPDATEFC_NP  = 4'h9;
    localparam logic [3:0] DLLP_UPDATEFC_CPL = 4'hA;

    typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} fc_type_e;
    typedef enum logic [1:0] {FCK_INIT1 = 2'd0, FCK_INIT2 = 2'd1, FCK_UPDATE = 2'd2} fc_kind_e;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_INIT = 16'hFFFF;

    // The CRC travels on the wire with the bits of each byte mirrored.
    function automatic logic [15:0] crc_byte_rev(input logic [15:0] c);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*b+j] = c[8*b+7-j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// DLLP CRC-16 (poly 0x100B) advanced over one dword, byte0 bit0 shifted in first.
// Latency: combinational.
// Backpressure: none.
module pcie_datalink_crc
    import pcie_datalink_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [31:0] data_i,
    output logic [15:0] crc_o
);

    // Serial LFSR unrolled over the 32 data bits in transmission order.
    always_comb begin
        logic [15:0] c;
        c = crc_i;
        for (int i = 0; i < 32; i++) begin
            if (c[15] ^ data_i[i]) begin
                c = {c[14:0], 1'b0} ^ DLLP_CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/pcie_dllp_fc_rx.sv
// Receives framed DLLPs, checks CRC, decodes VC FC DLLPs and holds the partner's credit limits.
// Latency: credit/flag outputs change 2 cycles after the CRC beat; crc_err_o 1 cycle after the bad beat.
// Backpressure: none, tready is constant 1 and one DLLP per two beats is sustained.
module pcie_dllp_fc_rx
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3,
    parameter int VC_ID      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fc_restart_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  fc1_values_stored_o,
    output logic                  fc2_values_stored_o,
    output logic [7:0]            p_hdr_credits_o,
    output logic [11:0]           p_data_credits_o,
    output logic [7:0]            np_hdr_credits_o,
    output logic [11:0]           np_data_credits_o,
    output logic [7:0]            cpl_hdr_credits_o,
    output logic [11:0]           cpl_data_credits_o,
    output logic                  update_fc_o,
    output logic                  crc_err_o
);

    localparam logic [2:0] VC_SEL = 3'(VC_ID);

    typedef enum logic [1:0] {ST_HDR, ST_CRC, ST_DROP} rx_state_e;

    rx_state_e        state_q, state_d;
    dllp_fc_t         beat_q, beat_d;
    logic             beat_err_q, beat_err_d;
    logic             proc_vld_q, proc_vld_d;
    fc_kind_e         proc_kind_q, proc_kind_d;
    fc_type_e         proc_idx_q, proc_idx_d;
    logic [7:0]       proc_hdr_q, proc_hdr_d;
    logic [11:0]      proc_data_q, proc_data_d;
    logic             crc_err_q, crc_err_d;
    logic [2:0]       mask_q, mask_d;
    logic             fc1_q, fc1_d;
    logic             fc2_q, fc2_d;
    logic             upd_q, upd_d;
    logic [2:0][7:0]  hdr_cr_q, hdr_cr_d;
    logic [2:0][11:0] data_cr_q, data_cr_d;
    logic [15:0]      crc_calc;
    logic             is_fc;
    fc_kind_e         dec_kind;
    fc_type_e         dec_idx;
    logic             unused_inputs;

    assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser[USER_WIDTH-1:1]};

    pcie_datalink_crc u_crc (
        .crc_i  (DLLP_CRC_INIT),
        .data_i (beat_q),
        .crc_o  (crc_calc)
    );

    // Classify the held dword: which FC kind and which credit type it targets.
    always_comb begin
        is_fc    = 1'b1;
        dec_kind = FCK_INIT1;
        dec_idx  = FC_P;
        case (beat_q.typ)
            DLLP_INITFC1_P:    begin dec_kind = FCK_INIT1;  dec_idx = FC_P;   end
            DLLP_INITFC1_NP:   begin dec_kind = FCK_INIT1;  dec_idx = FC_NP;  end
            DLLP_INITFC1_CPL:  begin dec_kind = FCK_INIT1;  dec_idx = FC_CPL; end
            DLLP_INITFC2_P:    begin dec_kind = FCK_INIT2;  dec_idx = FC_P;   end
            DLLP_INITFC2_NP:   begin dec_kind = FCK_INIT2;  dec_idx = FC_NP;  end
            DLLP_INITFC2_CPL:  begin dec_kind = FCK_INIT2;  dec_idx = FC_CPL; end
            DLLP_UPDATEFC_P:   begin dec_kind = FCK_UPDATE; dec_idx = FC_P;   end
            DLLP_UPDATEFC_NP:  begin dec_kind = FCK_UPDATE; dec_idx = FC_NP;  end
            DLLP_UPDATEFC_CPL: begin dec_kind = FCK_UPDATE; dec_idx = FC_CPL; end
            default:           is_fc = 1'b0;
        endcase
    end

    // Frame parser: hold beat 1, check CRC on beat 2, resync on tlast after malformed frames.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        beat_err_d  = beat_err_q;
        proc_vld_d  = 1'b0;
        proc_kind_d = proc_kind_q;
        proc_idx_d  = proc_idx_q;
        proc_hdr_d  = proc_hdr_q;
        proc_data_d = proc_data_q;
        crc_err_d   = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                ST_HDR: begin
                    beat_d     = dllp_fc_t'(s_axis_tdata[31:0]);
                    beat_err_d = s_axis_tuser[0];
                    if (s_axis_tlast) crc_err_d = 1'b1;
                    else              state_d   = ST_CRC;
                end
                ST_CRC: begin
                    if (!s_axis_tlast) begin
                        state_d   = ST_DROP;
                        crc_err_d = 1'b1;
                    end else begin
                        state_d = ST_HDR;
                        if (s_axis_tdata[15:0] != crc_byte_rev(crc_calc) ||
                            beat_err_q || s_axis_tuser[0]) begin
                            crc_err_d = 1'b1;
                        end else if (is_fc && beat_q.vc == VC_SEL) begin
                            proc_vld_d  = 1'b1;
                            proc_kind_d = dec_kind;
                            proc_idx_d  = dec_idx;
                            proc_hdr_d  = {beat_q.hdr_hi, beat_q.hdr_lo};
                            proc_data_d = {beat_q.data_hi, beat_q.data_lo};
                        end
                    end
                end
                ST_DROP: if (s_axis_tlast) state_d = ST_HDR;
                default: state_d = ST_HDR;
            endcase
        end
    end

    // FC state: capture InitFC once per type, track FC1/FC2 completion, apply UpdateFC after FC2.
    always_comb begin
        mask_d    = mask_q;
        hdr_cr_d  = hdr_cr_q;
        data_cr_d = data_cr_q;
        fc2_d     = fc2_q;
        upd_d     = 1'b0;
        if (proc_vld_q) begin
            case (proc_kind_q)
                FCK_INIT1, FCK_INIT2: begin
                    if (!fc2_q && !mask_q[proc_idx_q]) begin
                        hdr_cr_d[proc_idx_q]  = proc_hdr_q;
                        data_cr_d[proc_idx_q] = proc_data_q;
                        mask_d[proc_idx_q]    = 1'b1;
                    end
                    // Uses the registered fc1 flag: the DLLP completing the mask does not count.
                    if (proc_kind_q == FCK_INIT2 && fc1_q) fc2_d = 1'b1;
                end
                FCK_UPDATE: begin
                    if (fc2_q) begin
                        hdr_cr_d[proc_idx_q]  = proc_hdr_q;
                        data_cr_d[proc_idx_q] = proc_data_q;
                        upd_d                 = 1'b1;
                    end else if (fc1_q) begin
                        fc2_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        fc1_d = fc1_q | (&mask_d);
        if (fc_restart_i) begin
            mask_d    = '0;
            hdr_cr_d  = '0;
            data_cr_d = '0;
            fc1_d     = 1'b0;
            fc2_d     = 1'b0;
            upd_d     = 1'b0;
        end
    end

    // Parser and processing-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HDR;
            beat_q      <= '0;
            beat_err_q  <= 1'b0;
            proc_vld_q  <= 1'b0;
            proc_kind_q <= FCK_INIT1;
            proc_idx_q  <= FC_P;
            proc_hdr_q  <= '0;
            proc_data_q <= '0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            beat_err_q  <= beat_err_d;
            proc_vld_q  <= proc_vld_d;
            proc_kind_q <= proc_kind_d;
            proc_idx_q  <= proc_idx_d;
            proc_hdr_q  <= proc_hdr_d;
            proc_data_q <= proc_data_d;
            crc_err_q   <= crc_err_d;
        end
    end

    // Credit limits and FC handshake flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q    <= '0;
            fc1_q     <= 1'b0;
            fc2_q     <= 1'b0;
            upd_q     <= 1'b0;
            hdr_cr_q  <= '0;
            data_cr_q <= '0;
        end else begin
            mask_q    <= mask_d;
            fc1_q     <= fc1_d;
            fc2_q     <= fc2_d;
            upd_q     <= upd_d;
            hdr_cr_q  <= hdr_cr_d;
            data_cr_q <= data_cr_d;
        end
    end

    assign s_axis_tready       = 1'b1;
    assign fc1_values_stored_o = fc1_q;
    assign fc2_values_stored_o = fc2_q;
    assign update_fc_o         = upd_q;
    assign crc_err_o           = crc_err_q;
    assign p_hdr_credits_o     = hdr_cr_q[FC_P];
    assign p_data_credits_o    = data_cr_q[FC_P];
    assign np_hdr_credits_o    = hdr_cr_q[FC_NP];
    assign np_data_credits_o   = data_cr_q[FC_NP];
    assign cpl_hdr_credits_o   = hdr_cr_q[FC_CPL];
    assign cpl_data_credits_o  = data_cr_q[FC_CPL];

endmodule

// File: doc/pcie_dllp_fc_rx.md
Name: pcie_dllp_fc_rx

Overview:
- Receive-side DLLP flow-control consumer for the data link layer.
- Accepts CRC-framed DLLPs from the physical/framing stage over AXI-Stream and checks the 16-bit DLLP CRC.
- Decodes InitFC1/InitFC2/UpdateFC for VC0 and latches the link partner's advertised header/data credits for P, NP and Cpl.
- Produces the fc1_values_stored / fc2_values_stored handshakes that drive the flow-control init transmitter, plus credit-limit outputs for the TLP transmit gate.

Parameters:
- DATA_WIDTH, 32, stream data width; only 32 supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 3, tuser width; bit 0 = lower-layer error flag.
- VC_ID, 0, the only VC whose FC DLLPs are accepted.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- fc_restart_i  in  1  one-cycle pulse: clear FC state and re-enter FC_INIT1 (link retrain).
- s_axis_tdata  in  DATA_WIDTH  DLLP beats.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of DLLP.
- s_axis_tuser  in  USER_WIDTH  bit 0 = lower-layer error.
- s_axis_tready  out  1  always 1 out of reset.
- fc1_values_stored_o  out  1  level: P, NP and Cpl InitFC values captured.
- fc2_values_stored_o  out  1  level: FC_INIT2 complete.
- p_hdr_credits_o  out  8  posted header credit limit.
- p_data_credits_o  out  12  posted data credit limit.
- np_hdr_credits_o  out  8  non-posted header credit limit.
- np_data_credits_o  out  12  non-posted data credit limit.
- cpl_hdr_credits_o  out  8  completion header credit limit.
- cpl_data_credits_o  out  12  completion data credit limit.
- update_fc_o  out  1  one-cycle pulse: credit limit changed by UpdateFC.
- crc_err_o  out  1  one-cycle pulse: bad CRC, malformed frame or tuser error.

Behaviour:
- Reset: all outputs 0 except s_axis_tready=1. rst_i or fc_restart_i clears the credits, the stored flags and the captured-type mask. fc_restart_i takes priority over a DLLP completing in the same cycle.
- Frame format:
  - Beat 1: tdata[31:0] = DLLP bytes 0..3, byte0 in [7:0], tkeep=4'hF, tlast=0.
  - Beat 2: tdata[15:0] = CRC, bit-reversed within each byte, tkeep=4'h3, tlast=1.
- Field decode, from the package dllp_fc_t:
  - type = byte0[7:4]; vc = byte0[2:0].
  - HdrFC = {byte1[5:0], byte2[7:6]}.
  - DataFC = {byte2[3:0], byte3}.
- FSM:
  - ST_HDR: on a beat, register it. If tlast=1, pulse crc_err_o and stay. Otherwise go to ST_CRC.
  - ST_CRC: on a beat, compare the received CRC with the expected CRC. The expected CRC is pcie_datalink_crc(crcIn='1, registered dword), byte-bit-reversed. If tlast=0, go to ST_DROP and pulse crc_err_o. Otherwise go to ST_HDR and process the DLLP when the CRC matches and tuser[0] of both beats is 0. A mismatch or tuser error pulses crc_err_o and discards the DLLP.
  - ST_DROP: discard beats until a beat with tlast=1, then go to ST_HDR.
- Processing occurs in the cycle after the CRC beat handshake, so outputs change 2 cycles after that beat.
- Non-FC types (Ack, Nak, PM, vendor) and FC DLLPs with vc != VC_ID are discarded silently, with no error.
- Type mask, 3 bits: P, NP, Cpl.
  - InitFC1 or InitFC2 of a type whose mask bit is 0 latches that type's credits and sets the mask bit.
  - An InitFC of a type already captured is ignored; credits do not change.
  - fc1_values_stored_o rises the cycle the mask becomes 3'b111.
- fc2_values_stored_o rises on the first valid InitFC2 or UpdateFC processed while fc1_values_stored_o=1. The condition is evaluated against the registered fc1 flag, so a DLLP in the same cycle that completes the mask does not count.
- Before fc1 is complete, UpdateFC is ignored.
- After fc2_values_stored_o=1:
  - UpdateFC overwrites that type's hdr/data credits and pulses update_fc_o.
  - InitFC1/InitFC2 are ignored.
- A value of 0 in a credit field means infinite. It is stored as 0 unchanged; the interpretation belongs to the consumer.
- Back-to-back DLLPs on consecutive cycles are supported with no bubbles.

Decomposition:
- pcie_datalink_pkg holds:
  - dllp_fc_t;
  - the DLLP type encodings InitFC1_P/NP/Cpl (0x4/0x5/0x6), InitFC2_* (0xC/0xD/0xE) and UpdateFC_* (0x8/0x9/0xA);
  - an fc_type_e {FC_P, FC_NP, FC_CPL};
  - a crc byte-reverse function.
- Sub-module: reuse the existing pcie_datalink_crc, instanced once on the registered beat-1 dword.

Test Plan:
- InitFC1 P(hdr 1, data 16), NP(1,1), Cpl(0,0), each with correct CRC -> credits latched; fc1_values_stored_o rises 2 cycles after the Cpl CRC beat; fc2_values_stored_o stays 0.
- Then InitFC2_P(hdr 5, data 40) -> fc2_values_stored_o=1; p_hdr_credits_o stays 1; a following UpdateFC_P(hdr 9, data 64) -> p credits 9/64 and update_fc_o pulses once.
- InitFC1_P with one CRC bit flipped -> crc_err_o pulses; credits stay 0; the next good DLLP is accepted back-to-back.
- Three-beat frame, then a 1-beat frame with tlast on beat 1 -> crc_err_o pulses for each; ST_DROP resynchronises on tlast; a following good NP InitFC1 is latched.
- FC DLLP with vc=1, and an Ack DLLP -> no credit change, no crc_err_o.
- fc_restart_i asserted in the same cycle as an UpdateFC is processed -> all credits 0 and both flags 0 the next cycle; a repeated InitFC1 sequence completes FC1 again.
